pattern_sync_rx: RTL
====================

PATTERN_SYNC_RX -- requirements
Module: pattern_sync_rx

Interface
REQ-001 SHALL provide parameter PATTERN, default 8'b1011_0011, 8-bit frame pattern; bit 7 is transmitted first (phase 0), bit 0 last (phase 7).
REQ-002 SHALL provide parameter LOCK_FRAMES, default 2, consecutive error-free frames required in VERIFY to enter LOCK (range 1..15).
REQ-003 SHALL provide parameter LOSS_FRAMES, default 3, consecutive errored frames in LOCK that force return to SEARCH (range 1..15).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 din  input  1  serial pattern stream, one bit sampled per clk.
REQ-007 err_clr  input  1  synchronous clear of err_cnt.
REQ-008 locked  output  1  high while in LOCK state.
REQ-009 phase  output  3  frame position of the most recently sampled bit; valid only when locked=1, else 0.
REQ-010 frame_start  output  1  high when locked=1 and phase=0.
REQ-011 bit_err  output  1  one-cycle pulse: sampled bit differed from expected bit while in LOCK.
REQ-012 err_cnt  output  8  saturating LOCK bit-error count.

Function
REQ-013 SHALL shift din into an 8-bit register every cycle, newest bit in LSB; a 4-bit fill counter SHALL count samples since reset, saturating at 8.
REQ-014 SHALL implement states SEARCH, VERIFY, LOCK; SEARCH after reset.
REQ-015 SEARCH: when fill=8 and shift register (including current sample) equals PATTERN -> VERIFY, internal phase counter set so the next sample is phase 0, good-frame count cleared.
REQ-016 VERIFY: each sample compared with PATTERN bit at current phase; any mismatch -> SEARCH immediately (no bit_err pulse); at phase 7 with no mismatch in the frame, good count +1; reaching LOCK_FRAMES -> LOCK.
REQ-017 LOCK: each sample compared with expected bit; mismatch pulses bit_err and marks frame errored; at phase 7 an errored frame increments bad count, an error-free frame clears it; bad count reaching LOSS_FRAMES -> SEARCH.
REQ-018 Internal phase counter SHALL wrap 7 -> 0 and free-run in VERIFY and LOCK.
REQ-019 All outputs SHALL be registered: effects of the sample taken at edge N appear after edge N, one-cycle latency, no combinational path din -> output.
REQ-020 Transition to SEARCH SHALL not clear the shift register or fill counter; a realigned match can occur on the very next sample.
REQ-021 err_cnt increments on each bit_err, holds at 255; err_clr and a simultaneous error -> err_cnt=0 (clear wins).

Reset
REQ-022 rst=1 SHALL immediately force: state SEARCH, shift register 0, fill 0, phase/good/bad counts 0, locked=0, phase=0, frame_start=0, bit_err=0, err_cnt=0.
REQ-023 Reset asserted mid-frame SHALL discard all alignment; relock requires full 8-sample fill again.

Configuration
REQ-024 Macro ERR_CNT_EN: when defined, err_cnt and err_clr behave per REQ-021; when undefined, err_cnt SHALL be driven constant 0, err_clr ignored, no counter logic synthesised; bit_err unaffected.

Verification
REQ-025 Continuous 10110011 stream from first post-reset sample (default parameters) -> locked=1 after the edge sampling bit 24; thereafter frame_start high every 8th cycle, phase cycling 0..7, bit_err never high.
REQ-026 Locked, invert phase-3 bit in three consecutive frames -> three bit_err pulses, err_cnt=3, locked falls after phase-7 sample of third errored frame.
REQ-027 Locked, one errored frame then clean frames -> locked stays 1, bad count reset; a later two errored frames do not unlock.
REQ-028 Stream started at phase 5 (bits 0,1,1 then frames) -> no false match on partial fill; locked only after true alignment plus 2 verified frames; phase values consistent with transmitted phase.
REQ-029 Force 300 errors in LOCK with ERR_CNT_EN defined -> err_cnt=255; err_clr pulse coincident with error -> err_cnt=0; without macro err_cnt stays 0.
REQ-030 rst pulse mid-LOCK -> all outputs 0 asynchronously; relock after 24 further correct samples.

Source files
------------

// File: rtl/pattern_sync_rx.sv
// Serial frame-pattern synchroniser: searches, verifies and tracks an 8-bit repeating pattern.
// Optional saturating bit-error counter enabled by defining ERR_CNT_EN.
module pattern_sync_rx #(
  parameter logic [7:0]  PATTERN     = 8'b1011_0011,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned LOSS_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       err_clr,
  output logic       locked,
  output logic [2:0] phase,
  output logic       frame_start,
  output logic       bit_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] fill_q, fill_d;
  logic [2:0] ph_q, ph_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic       ferr_q, ferr_d;
  logic       locked_q, locked_d;
  logic [2:0] phase_q, phase_d;
  logic       fs_q, fs_d;
  logic       be_q, be_d;
  logic       mismatch_s;

  // ph_q is the frame position of the sample arriving on this edge
  assign mismatch_s = din != PATTERN[3'd7 - ph_q];

  // next-state logic for alignment FSM, counters and outputs
  always_comb begin
    sr_d    = {sr_q[6:0], din};
    fill_d  = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
    state_d = state_q;
    ph_d    = ph_q;
    good_d  = good_q;
    bad_d   = bad_q;
    ferr_d  = ferr_q;
    be_d    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (fill_d == 4'd8 && sr_d == PATTERN) begin
          state_d = VERIFY;
          ph_d    = 3'd0;
          good_d  = 4'd0;
        end else begin
          state_d = SEARCH;
        end
      end
      VERIFY: begin
        ph_d = ph_q + 3'd1;
        if (mismatch_s) begin
          state_d = SEARCH;
        end else if (ph_q == 3'd7) begin
          good_d = good_q + 4'd1;
          if (good_d == LOCK_N) begin
            state_d = LOCK;
            bad_d   = 4'd0;
            ferr_d  = 1'b0;
          end else begin
            state_d = VERIFY;
          end
        end else begin
          state_d = VERIFY;
        end
      end
      LOCK: begin
        ph_d = ph_q + 3'd1;
        be_d = mismatch_s;
        if (ph_q == 3'd7) begin
          ferr_d = 1'b0;
          if (ferr_q || mismatch_s) begin
            bad_d = bad_q + 4'd1;
            if (bad_d == LOSS_N) begin
              state_d = SEARCH;
            end else begin
              state_d = LOCK;
            end
          end else begin
            bad_d = 4'd0;
          end
        end else begin
          ferr_d = ferr_q | mismatch_s;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCK);
    phase_d  = locked_d ? ph_q : 3'd0;
    fs_d     = locked_d && (ph_q == 3'd0);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      sr_q     <= 8'd0;
      fill_q   <= 4'd0;
      ph_q     <= 3'd0;
      good_q   <= 4'd0;
      bad_q    <= 4'd0;
      ferr_q   <= 1'b0;
      locked_q <= 1'b0;
      phase_q  <= 3'd0;
      fs_q     <= 1'b0;
      be_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      ph_q     <= ph_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      ferr_q   <= ferr_d;
      locked_q <= locked_d;
      phase_q  <= phase_d;
      fs_q     <= fs_d;
      be_q     <= be_d;
    end
  end

  assign locked      = locked_q;
  assign phase       = phase_q;
  assign frame_start = fs_q;
  assign bit_err     = be_q;

`ifdef ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // clear has priority over a coincident error
  always_comb begin
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if (be_d && err_cnt_q != 8'd255) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign err_cnt        = 8'd0;
`endif

endmodule
